// File: rtl/parity_pkg.sv
// Shared state encoding and default widths for the frame parity generator/checker.
package parity_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcc    = 2'd1,
    StReport = 2'd2
  } state_e;

endpackage

// File: rtl/parity_word.sv
// Combinational XOR reduction of one data word; reusable by any parity block.
module parity_word #(
  parameter int unsigned DATA_W = parity_pkg::DefDataW
) (
  input  logic [DATA_W-1:0] d,
  output logic              p
);

  always_comb begin
    p = ^d;
  end

endmodule

// File: rtl/parity_gen_chk.sv
// Frame parity generator/checker: folds every accepted word into a running parity and
// reports parity, optional mismatch and word count for one cycle after the last beat.
module parity_gen_chk
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              odd_sel,
  input  logic              chk_en,
  input  logic              chk_par,
  output logic              in_ready,
  output logic              par_valid,
  output logic              par_out,
  output logic              par_err,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e             state_q, state_d;
  logic               acc_q, acc_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_valid_q, par_valid_d;
  logic               par_out_q, par_out_d;
  logic               par_err_q, par_err_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic               word_par;
  logic               beat;
  logic [CNT_W-1:0]   cnt_inc;

  parity_word #(
    .DATA_W (DATA_W)
  ) u_parity_word (
    .d (in_data),
    .p (word_par)
  );

  assign in_ready = (state_q != StReport);
  assign busy     = (state_q != StIdle);
  assign beat     = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    par_valid_d = 1'b0;
    par_out_d   = par_out_q;
    par_err_d   = 1'b0;
    word_cnt_d  = word_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (beat) begin
          acc_d   = word_par;
          mode_d  = odd_sel;
          cnt_d   = CntOne;
          state_d = in_last ? StReport : StAcc;
        end
      end
      StAcc: begin
        if (beat) begin
          acc_d = acc_q ^ word_par;
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d = StReport;
          end
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Result is registered on the last beat so it is visible during the REPORT cycle.
    if (beat && in_last) begin
      par_valid_d = 1'b1;
      par_out_d   = acc_d ^ mode_d;
      word_cnt_d  = cnt_d;
      par_err_d   = chk_en && (chk_par != par_out_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= 1'b0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      par_valid_q <= 1'b0;
      par_out_q   <= 1'b0;
      par_err_q   <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      par_valid_q <= par_valid_d;
      par_out_q   <= par_out_d;
      par_err_q   <= par_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign par_valid = par_valid_q;
  assign par_out   = par_out_q;
  assign par_err   = par_err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Scoreboard bench: a wide instance (8-bit words, 3-bit count) and a narrow one (3-bit
// words, 2-bit count) share one clock and reset.
module tb_parity_gen_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       m_in_valid, m_in_last, m_odd_sel, m_chk_en, m_chk_par;
  logic [7:0] m_in_data;
  logic       m_in_ready, m_par_valid, m_par_out, m_par_err, m_busy;
  logic [2:0] m_word_cnt;

  logic       s_in_valid, s_in_last, s_odd_sel, s_chk_en, s_chk_par;
  logic [2:0] s_in_data;
  logic       s_in_ready, s_par_valid, s_par_out, s_par_err, s_busy;
  logic [1:0] s_word_cnt;

  parity_gen_chk #(.DATA_W(8), .CNT_W(3)) u_dut_main (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_in_valid),
    .in_data   (m_in_data),
    .in_last   (m_in_last),
    .odd_sel   (m_odd_sel),
    .chk_en    (m_chk_en),
    .chk_par   (m_chk_par),
    .in_ready  (m_in_ready),
    .par_valid (m_par_valid),
    .par_out   (m_par_out),
    .par_err   (m_par_err),
    .word_cnt  (m_word_cnt),
    .busy      (m_busy)
  );

  parity_gen_chk #(.DATA_W(3), .CNT_W(2)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .odd_sel   (s_odd_sel),
    .chk_en    (s_chk_en),
    .chk_par   (s_chk_par),
    .in_ready  (s_in_ready),
    .par_valid (s_par_valid),
    .par_out   (s_par_out),
    .par_err   (s_par_err),
    .word_cnt  (s_word_cnt),
    .busy      (s_busy)
  );

  typedef struct {
    bit par;
    bit err;
    int cnt;
    int cyc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t em, es;
  int   checks  = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   busy_m  = 0;
  int   bubbles = 0;
  bit   armed   = 1'b0;

  function automatic void check(string name, int got, int exp_v);
    checks++;
    if (got != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp_v, cyc);
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_busy) busy_m <= busy_m + 1;
    if (m_in_valid && !m_in_ready) bubbles <= bubbles + 1;
  end

  // Monitors: pop one expectation per par_valid cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("m_ready_vs_report", int'(m_in_ready), int'(!m_par_valid));
      if (!m_par_valid) begin
        check("m_err_without_valid", int'(m_par_err), 0);
      end else if (q_m.size() == 0) begin
        check("m_unexpected_valid", 1, 0);
      end else begin
        em = q_m.pop_front();
        check("m_par_out", int'(m_par_out), int'(em.par));
        check("m_par_err", int'(m_par_err), int'(em.err));
        check("m_word_cnt", int'(m_word_cnt), em.cnt);
        check("m_latency_cycle", cyc, em.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("s_ready_vs_report", int'(s_in_ready), int'(!s_par_valid));
      if (!s_par_valid) begin
        check("s_err_without_valid", int'(s_par_err), 0);
      end else if (q_s.size() == 0) begin
        check("s_unexpected_valid", 1, 0);
      end else begin
        es = q_s.pop_front();
        check("s_par_out", int'(s_par_out), int'(es.par));
        check("s_par_err", int'(s_par_err), int'(es.err));
        check("s_word_cnt", int'(s_word_cnt), es.cnt);
        check("s_latency_cycle", cyc, es.cyc);
      end
    end
  end

  task automatic drive(input bit sel, input bit v, input logic [7:0] d, input bit l,
                       input bit o, input bit ce, input bit cp);
    if (sel) begin
      s_in_valid = v; s_in_data = d[2:0]; s_in_last = l;
      s_odd_sel = o; s_chk_en = ce; s_chk_par = cp;
    end else begin
      m_in_valid = v; m_in_data = d; m_in_last = l;
      m_odd_sel = o; m_chk_en = ce; m_chk_par = cp;
    end
  endtask

  // Reference: parity is the popcount of the whole frame mod 2, inverted for odd mode.
  task automatic send_frame(input bit sel, input logic [7:0] w[$], input bit odd,
                            input bit ce, input bit cp, input int gap_pct,
                            input bit drop_last);
    int ones;
    int tries;
    int cmax;
    bit rdy;
    bit last;
    logic [7:0] d;
    exp_t e;
    ones = 0;
    cmax = sel ? 3 : 7;
    for (int i = 0; i < w.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        drive(sel, 1'b0, 8'h00, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
      end
      d = sel ? (w[i] & 8'h07) : w[i];
      last = (i == w.size() - 1) && !drop_last;
      ones += $countones(d);
      drive(sel, 1'b1, d, last, (i == 0) ? odd : 1'($urandom),
            last ? ce : 1'($urandom), last ? cp : 1'($urandom));
      tries = 0;
      forever begin
        rdy = sel ? s_in_ready : m_in_ready;
        if (rdy && last) begin
          e.par = ones[0] ^ odd;
          e.err = ce && (cp != e.par);
          e.cnt = (w.size() > cmax) ? cmax : w.size();
          e.cyc = cyc + 1;
          if (sel) q_s.push_back(e);
          else q_m.push_back(e);
        end
        @(negedge clk);
        if (rdy) break;
        tries++;
        if (tries > 8) begin
          check("handshake_timeout", 0, 1);
          break;
        end
      end
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_par_valid", int'(m_par_valid), 0);
    check("rst_par_out", int'(m_par_out), 0);
    check("rst_par_err", int'(m_par_err), 0);
    check("rst_word_cnt", int'(m_word_cnt), 0);
    check("rst_busy", int'(m_busy), 0);
    check("rst_in_ready", int'(m_in_ready), 1);
    check("rst_s_word_cnt", int'(s_word_cnt), 0);
    check("rst_s_busy", int'(s_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wq[$];
    int b0;
    int n;
    idle_all();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    armed = 1'b1;

    // Narrow instance: every 3-bit single-word frame in odd mode, back to back.
    for (int v = 0; v < 8; v++) begin
      wq.delete();
      wq.push_back(8'(v));
      send_frame(1'b1, wq, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    end
    idle_all();
    @(negedge clk);
    // Five-word frame saturates the 2-bit counter at 3.
    wq.delete();
    for (int k = 0; k < 5; k++) wq.push_back(8'($urandom));
    send_frame(1'b1, wq, 1'($urandom), 1'b1, 1'($urandom), 0, 1'b0);
    idle_all();
    @(negedge clk);

    // Even frame 01,03,80: parity 0, three words, busy for three cycles.
    wq.delete();
    wq.push_back(8'h01); wq.push_back(8'h03); wq.push_back(8'h80);
    b0 = busy_m;
    send_frame(1'b0, wq, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle_all();
    repeat (4) @(negedge clk);
    check("busy_cycles", busy_m - b0, 3);

    // Same frame, odd mode, checked against both received parity values.
    send_frame(1'b0, wq, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle_all();
    @(negedge clk);
    send_frame(1'b0, wq, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle_all();
    @(negedge clk);

    // Reset after two beats discards the frame; next frame 0x07 even.
    wq.delete();
    wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    send_frame(1'b0, wq, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    wq.delete();
    wq.push_back(8'h07);
    send_frame(1'b0, wq, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle_all();
    @(negedge clk);

    // in_valid held across four frames: one bubble per REPORT between frames.
    b0 = bubbles;
    for (int f = 0; f < 4; f++) begin
      wq.delete();
      n = (f == 2) ? 3 : ((f == 1) ? 1 : 2);
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      send_frame(1'b0, wq, 1'($urandom), 1'b1, 1'($urandom), 0, 1'b0);
    end
    idle_all();
    repeat (3) @(negedge clk);
    check("back_to_back_bubbles", bubbles - b0, 3);

    // Random frames with random gaps, lengths up to past counter saturation.
    for (int f = 0; f < 60; f++) begin
      wq.delete();
      n = $urandom_range(10, 1);
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      send_frame(1'b0, wq, 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(1) == 1) ? 30 : 0, 1'b0);
      if ($urandom_range(3) == 0) begin
        idle_all();
        @(negedge clk);
      end
    end
    idle_all();
    repeat (5) @(negedge clk);
    check("m_queue_drained", q_m.size(), 0);
    check("s_queue_drained", q_s.size(), 0);
    armed = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
